// File: rtl/multiplier_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : multiplier_sequencer
// Brief    : Control and buffering stage for a shift-and-add multiplier
//            datapath. Accepts operand pairs over a valid/ready handshake,
//            strobes the datapath through one init and N shift cycles, and
//            presents the 2N-bit product over an output valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module multiplier_sequencer #(
  parameter int N = 4  // operand width, must be at least 2
) (
  input  logic             clock,
  input  logic             reset,
  // upstream operand handshake
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_multiplicand,
  input  logic [N-1:0]     in_multiplier,
  // downstream result handshake
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   out_product,
  // datapath control and data
  output logic             do_init,
  output logic             do_shift,
  output logic [N-1:0]     dp_multiplicand,
  output logic [N-1:0]     dp_multiplier,
  input  logic [2*N-1:0]   dp_product,
  // status
  output logic             busy
);

  // Counter only has to hold N-1, so ceil(log2(N)) bits are enough.
  localparam int            CW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(N - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_INIT  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_WB    = 2'd3;

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   mcand_q, mcand_d;
  logic [N-1:0]   mplier_q, mplier_d;
  logic           out_valid_q, out_valid_d;
  logic [2*N-1:0] product_q, product_d;

  logic           w_accept;
  logic           w_out_free;
  logic           w_wb_load;
  logic           w_cnt_zero;

  // An operand pair is taken only while idle; the output register is free
  // when empty or when its current contents leave in this very cycle.
  assign w_accept   = (state_q == S_IDLE) && in_valid;
  assign w_out_free = !out_valid_q || out_ready;
  assign w_wb_load  = (state_q == S_WB) && w_out_free;
  assign w_cnt_zero = (cnt_q == '0);

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: one init cycle, N shift cycles, then write-back
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid)   state_d = S_INIT;
      S_INIT:                  state_d = S_SHIFT;
      S_SHIFT: if (w_cnt_zero) state_d = S_WB;
      S_WB:    if (w_out_free) state_d = S_IDLE;
      default:                 state_d = S_IDLE;
    endcase
  end

  // Output decode: strobes and status come straight from the state register
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b1;
    do_init  = 1'b0;
    do_shift = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      S_INIT:  do_init  = 1'b1;
      S_SHIFT: do_shift = 1'b1;
      S_WB:    ;
      default: begin
        in_ready = 1'b0;
        busy     = 1'b1;
      end
    endcase
  end

  // Next values of the operand, counter and result registers
  always_comb begin
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    product_d   = product_q;

    // Operands are frozen after capture so the datapath sees stable values.
    if (w_accept) begin
      mcand_d  = in_multiplicand;
      mplier_d = in_multiplier;
    end

    // The counter counts down the remaining shift cycles after this one.
    if (state_q == S_INIT) begin
      cnt_d = CNT_LOAD;
    end else if ((state_q == S_SHIFT) && !w_cnt_zero) begin
      cnt_d = cnt_q - 1'b1;
    end

    // A write-back reload takes priority over a drain in the same cycle.
    if (w_wb_load) begin
      product_d   = dp_product;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Operand, counter and result registers
  always_ff @(posedge clock) begin
    if (reset) begin
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      product_q   <= '0;
    end else begin
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      product_q   <= product_d;
    end
  end

  assign dp_multiplicand = mcand_q;
  assign dp_multiplier   = mplier_q;
  assign out_valid       = out_valid_q;
  assign out_product     = product_q;

endmodule
`default_nettype wire

// File: tb/tb_multiplier_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_multiplier_sequencer
// Brief    : Directed self-checking bench for multiplier_sequencer (N=4 and
//            N=8) with a behavioural shift-and-add datapath attached.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multiplier_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;

  // N=4 instance signals
  logic       iv4 = 1'b0, ir4, ov4, ordy4 = 1'b1, init4, shift4, busy4;
  logic [3:0] mc4 = '0, mp4 = '0, dpmc4, dpmp4;
  logic [7:0] prod4, dpprod4;

  // N=8 instance signals
  logic        iv8 = 1'b0, ir8, ov8, ordy8 = 1'b1, init8, shift8, busy8;
  logic [7:0]  mc8 = '0, mp8 = '0, dpmc8, dpmp8;
  logic [15:0] prod8, dpprod8;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int ovl_err = 0;
  int cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  multiplier_sequencer #(.N(4)) dut4 (
    .clock(clock), .reset(reset),
    .in_valid(iv4), .in_ready(ir4),
    .in_multiplicand(mc4), .in_multiplier(mp4),
    .out_valid(ov4), .out_ready(ordy4), .out_product(prod4),
    .do_init(init4), .do_shift(shift4),
    .dp_multiplicand(dpmc4), .dp_multiplier(dpmp4), .dp_product(dpprod4),
    .busy(busy4)
  );

  multiplier_sequencer #(.N(8)) dut8 (
    .clock(clock), .reset(reset),
    .in_valid(iv8), .in_ready(ir8),
    .in_multiplicand(mc8), .in_multiplier(mp8),
    .out_valid(ov8), .out_ready(ordy8), .out_product(prod8),
    .do_init(init8), .do_shift(shift8),
    .dp_multiplicand(dpmc8), .dp_multiplier(dpmp8), .dp_product(dpprod8),
    .busy(busy8)
  );

  // Behavioural shift-and-add datapaths: {a,q}, a cleared on init,
  // each shift adds the multiplicand when q[0] is set and shifts right.
  logic [3:0] a4 = '0, q4 = '0;
  logic [4:0] sum4;
  assign sum4    = {1'b0, a4} + (q4[0] ? {1'b0, dpmc4} : 5'd0);
  assign dpprod4 = {a4, q4};
  always @(posedge clock) begin
    if (init4) begin
      a4 <= '0;
      q4 <= dpmp4;
    end else if (shift4) begin
      a4 <= sum4[4:1];
      q4 <= {sum4[0], q4[3:1]};
    end
  end

  logic [7:0] a8 = '0, q8 = '0;
  logic [8:0] sum8;
  assign sum8    = {1'b0, a8} + (q8[0] ? {1'b0, dpmc8} : 9'd0);
  assign dpprod8 = {a8, q8};
  always @(posedge clock) begin
    if (init8) begin
      a8 <= '0;
      q8 <= dpmp8;
    end else if (shift8) begin
      a8 <= sum8[8:1];
      q8 <= {sum8[0], q8[7:1]};
    end
  end

  // Strobes must never overlap in either instance.
  always @(negedge clock) begin
    assert (!(init4 && shift4) && !(init8 && shift8))
    else begin
      ovl_err++;
      $error("FAIL strobe_overlap: init4=%0b shift4=%0b init8=%0b shift8=%0b required no overlap",
             init4, shift4, init8, shift8);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ready4(input int lim);
    int k = 0;
    while (!ir4 && k < lim) begin
      @(negedge clock);
      k++;
    end
    if (!ir4) chk("timeout_in_ready4", 64'(ir4), 64'd1);
  endtask

  task automatic wait_ov4(input int lim);
    int k = 0;
    while (!ov4 && k < lim) begin
      @(negedge clock);
      k++;
    end
    if (!ov4) chk("timeout_out_valid4", 64'(ov4), 64'd1);
  endtask

  initial begin
    int prev_acc;
    logic [7:0] exp_p;

    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // ---------------- reset state ----------------
    chk("rst_in_ready", 64'(ir4), 64'd1);
    chk("rst_busy", 64'(busy4), 64'd0);
    chk("rst_out_valid", 64'(ov4), 64'd0);
    chk("rst_out_product", 64'(prod4), 64'd0);
    chk("rst_do_init", 64'(init4), 64'd0);
    chk("rst_do_shift", 64'(shift4), 64'd0);
    chk("rst_dp_mcand", 64'(dpmc4), 64'd0);
    chk("rst_dp_mplier", 64'(dpmp4), 64'd0);

    // ---------------- 3 x 5 cycle-by-cycle ----------------
    mc4 = 4'd3; mp4 = 4'd5; iv4 = 1'b1;          // cycle 0
    @(negedge clock); iv4 = 1'b0;                // cycle 1
    chk("t1_c1_in_ready", 64'(ir4), 64'd0);
    chk("t1_c1_do_init", 64'(init4), 64'd1);
    chk("t1_c1_do_shift", 64'(shift4), 64'd0);
    for (int c = 2; c <= 5; c++) begin
      @(negedge clock);
      chk("t1_shift_do_shift", 64'(shift4), 64'd1);
      chk("t1_shift_do_init", 64'(init4), 64'd0);
    end
    @(negedge clock);                            // cycle 6
    chk("t1_c6_do_shift", 64'(shift4), 64'd0);
    chk("t1_c6_out_valid", 64'(ov4), 64'd0);
    chk("t1_c6_busy", 64'(busy4), 64'd1);
    @(negedge clock);                            // cycle 7
    chk("t1_c7_out_valid", 64'(ov4), 64'd1);
    chk("t1_c7_out_product", 64'(prod4), 64'd15);
    chk("t1_c7_in_ready", 64'(ir4), 64'd1);

    // ---------------- full sweep, back-to-back ----------------
    prev_acc = 0;
    exp_p = '0;
    mc4 = 4'd0; mp4 = 4'd0; iv4 = 1'b1;
    for (int i = 0; i < 256; i++) begin
      wait_ready4(20);
      if (i > 0) chk("sweep_accept_interval", 64'(cyc - prev_acc), 64'd7);
      prev_acc = cyc;
      exp_p = 8'(mc4) * 8'(mp4);
      @(negedge clock);
      if (i < 255) begin
        mc4 = 4'((i + 1) >> 4);
        mp4 = 4'((i + 1) & 15);
      end else begin
        iv4 = 1'b0;
      end
      wait_ov4(20);
      chk("sweep_product", 64'(prod4), 64'(exp_p));
    end
    chk("sweep_last_15x15", 64'(prod4), 64'd225);
    @(negedge clock);                            // last result drained
    ordy4 = 1'b0;
    chk("drain_out_valid", 64'(ov4), 64'd0);

    // ---------------- backpressure: A=7x9 then B=2x6 ----------------
    mc4 = 4'd7; mp4 = 4'd9; iv4 = 1'b1;
    @(negedge clock); iv4 = 1'b0;
    wait_ov4(20);
    chk("bp_A_product", 64'(prod4), 64'd63);
    mc4 = 4'd2; mp4 = 4'd6; iv4 = 1'b1;          // B accept cycle
    @(negedge clock); iv4 = 1'b0;                // B cycle 1
    chk("bp_hold_c1_product", 64'(prod4), 64'd63);
    chk("bp_hold_c1_valid", 64'(ov4), 64'd1);
    repeat (5) @(negedge clock);                 // B cycle 6: WB, stalled
    chk("bp_wb_busy", 64'(busy4), 64'd1);
    chk("bp_wb_in_ready", 64'(ir4), 64'd0);
    chk("bp_wb_strobes", 64'({init4, shift4}), 64'd0);
    chk("bp_wb_product", 64'(prod4), 64'd63);
    repeat (2) @(negedge clock);
    chk("bp_stall_busy", 64'(busy4), 64'd1);
    chk("bp_stall_product", 64'(prod4), 64'd63);
    ordy4 = 1'b1;
    @(negedge clock); ordy4 = 1'b0;
    chk("bp_reload_valid", 64'(ov4), 64'd1);
    chk("bp_reload_product", 64'(prod4), 64'd12);
    chk("bp_reload_busy", 64'(busy4), 64'd0);
    chk("bp_reload_in_ready", 64'(ir4), 64'd1);
    ordy4 = 1'b1;
    @(negedge clock);
    chk("bp_final_drain", 64'(ov4), 64'd0);

    // ---------------- operand stability: 11x13 ----------------
    mc4 = 4'd11; mp4 = 4'd13; iv4 = 1'b1;
    @(negedge clock); iv4 = 1'b0;                // cycle 1
    for (int k = 0; k < 5; k++) begin
      mc4 = 4'(k);
      mp4 = 4'(k + 1);
      @(negedge clock);
      chk("stab_dp_mcand", 64'(dpmc4), 64'd11);
      chk("stab_dp_mplier", 64'(dpmp4), 64'd13);
    end
    wait_ov4(20);
    chk("stab_product", 64'(prod4), 64'd143);
    @(negedge clock);                            // 143 drained

    // ---------------- reset mid-operation ----------------
    ordy4 = 1'b0;
    mc4 = 4'd4; mp4 = 4'd5; iv4 = 1'b1;
    @(negedge clock); iv4 = 1'b0;
    wait_ov4(20);
    chk("rstmid_pending", 64'(prod4), 64'd20);
    mc4 = 4'd6; mp4 = 4'd6; iv4 = 1'b1;          // accept 6x6
    @(negedge clock); iv4 = 1'b0;                // cycle 1
    repeat (2) @(negedge clock);                 // cycle 3, SHIFT
    chk("rstmid_in_shift", 64'(shift4), 64'd1);
    reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    chk("rstmid_busy", 64'(busy4), 64'd0);
    chk("rstmid_in_ready", 64'(ir4), 64'd1);
    chk("rstmid_out_valid", 64'(ov4), 64'd0);
    chk("rstmid_out_product", 64'(prod4), 64'd0);
    chk("rstmid_strobes", 64'({init4, shift4}), 64'd0);
    chk("rstmid_dp_mcand", 64'(dpmc4), 64'd0);
    ordy4 = 1'b1;
    mc4 = 4'd2; mp4 = 4'd3; iv4 = 1'b1;
    @(negedge clock); iv4 = 1'b0;
    wait_ov4(20);
    chk("rstmid_after_2x3", 64'(prod4), 64'd6);

    // ---------------- N=8: 255 x 255 ----------------
    chk("n8_idle_ready", 64'(ir8), 64'd1);
    mc8 = 8'd255; mp8 = 8'd255; iv8 = 1'b1;      // cycle 0
    @(negedge clock); iv8 = 1'b0;                // cycle 1
    chk("n8_c1_do_init", 64'(init8), 64'd1);
    repeat (9) @(negedge clock);                 // cycle 10: WB
    chk("n8_c10_out_valid", 64'(ov8), 64'd0);
    chk("n8_c10_busy", 64'(busy8), 64'd1);
    @(negedge clock);                            // cycle 11
    chk("n8_c11_out_valid", 64'(ov8), 64'd1);
    chk("n8_c11_product", 64'(prod8), 64'd65025);

    chk("no_strobe_overlap", 64'(ovl_err), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
